// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, then shifts a command byte out on device clock edges.
// Open-drain style: *_oe=1 means pull the line low; the top level turns that into 1'b0 / 1'bz.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic [3:0] state_dbg
);

  localparam int TMAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int TMAX   = (TMAX_A > FRAME_TIMEOUT) ? TMAX_A : FRAME_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int FW     = $clog2(FILTER_CYCLES + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] FRAME_LAST   = TW'(FRAME_TIMEOUT - 1);
  localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INHIBIT    = 4'd1,
    S_RTS        = 4'd2,
    S_WAIT_START = 4'd3,
    S_DATA       = 4'd4,
    S_ACK        = 4'd5,
    S_WAIT_IDLE  = 4'd6,
    S_DONE       = 4'd7,
    S_ERR        = 4'd8
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic [3:0]    bitcnt;
  logic [9:0]    shift;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  assign state_dbg = state;
  assign timer_inc = (&timer) ? timer : timer + 1'b1;

  // Synchronizers idle high like the bus; a clock level change is accepted
  // only after FILTER_CYCLES consecutive cycles of the new level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILTER_LAST) begin
        filt_cnt <= '0;
        clk_filt <= clk_s2;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Handshake: a byte is taken on any rising clock edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so tx_valid is ignored for the whole transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      bitcnt     <= '0;
      shift      <= '0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            timer      <= '0;
            bitcnt     <= '0;
            state      <= S_INHIBIT;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end
        end
        S_INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            timer      <= '0;
            state      <= S_RTS;
            ps2_dat_oe <= 1'b1;
          end else begin
            timer <= timer_inc;
          end
        end
        S_RTS: begin
          timer      <= '0;
          state      <= S_WAIT_START;
          ps2_clk_oe <= 1'b0;
        end
        S_WAIT_START: begin
          if (fall) begin
            ps2_dat_oe <= ~shift[0];
            bitcnt     <= 4'd1;
            timer      <= '0;
            state      <= S_DATA;
          end else if (timer == START_LAST) begin
            state      <= S_ERR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DATA: begin
          if (timer == FRAME_LAST) begin
            state      <= S_ERR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            timer <= timer_inc;
            if (fall) begin
              // bitcnt 9 places the stop bit (shift[9]=1 -> line released)
              ps2_dat_oe <= ~shift[bitcnt];
              bitcnt     <= bitcnt + 4'd1;
              if (bitcnt == 4'd9) state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          ps2_dat_oe <= 1'b0;
          if (timer == FRAME_LAST) begin
            state      <= S_ERR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
          end else begin
            timer <= timer_inc;
            if (fall) begin
              if (!dat_s2) begin
                state <= S_WAIT_IDLE;
              end else begin
                state      <= S_ERR;
                tx_error   <= 1'b1;
                ps2_clk_oe <= 1'b0;
              end
            end
          end
        end
        S_WAIT_IDLE: begin
          if (timer == FRAME_LAST) begin
            state      <= S_ERR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            timer <= timer_inc;
            if (clk_filt && dat_s2) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          state      <= S_IDLE;
          timer      <= '0;
          bitcnt     <= '0;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          timer      <= '0;
          bitcnt     <= '0;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
